// File: rtl/hbridge_deadtime_guard.sv
// Shoot-through guard between the H-bridge controller and the motor driver pins.
// Each channel coasts for DEADTIME cycles before any new drive direction is applied.
module hbridge_deadtime_guard #(
    parameter int unsigned DEADTIME = 1000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic [1:0] m1_ctrl_in,
    input  logic       m1_pwm_in,
    input  logic [1:0] m2_ctrl_in,
    input  logic       m2_pwm_in,
    input  logic       fault_clr,
    output logic [1:0] motor1_ctrl,
    output logic       motor1_pwm,
    output logic [1:0] motor2_ctrl,
    output logic       motor2_pwm,
    output logic [1:0] dead_active,
    output logic [1:0] fault
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0][1:0] ctrl_raw;
    logic [1:0]      pwm_raw;
    logic [1:0]      illegal;
    logic [1:0][1:0] ctrl_out;
    logic [1:0]      pwm_out;
    logic [1:0]      dead_out;
    logic [1:0]      fault_q, fault_d;

    assign ctrl_raw = {m2_ctrl_in, m1_ctrl_in};
    assign pwm_raw  = {m2_pwm_in, m1_pwm_in};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [1:0]       cur_q, cur_d;
        logic [1:0]       pend_q, pend_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [1:0]       ctrl_q, ctrl_d;
        logic             pwm_q, pwm_d;
        logic             dead_q, dead_d;
        logic [1:0]       new_ctrl;

        assign illegal[g] = (ctrl_raw[g] == 2'b11);
        assign new_ctrl   = illegal[g] ? 2'b00 : ctrl_raw[g];

        always_comb begin
            state_d = state_q;
            cur_d   = cur_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_RUN: begin
                    cnt_d = '0;
                    if (new_ctrl != cur_q) begin
                        if (new_ctrl == 2'b00) begin
                            cur_d = 2'b00;
                        end else begin
                            state_d = ST_DEAD;
                            pend_d  = new_ctrl;
                            cnt_d   = DEAD_LOAD;
                        end
                    end
                end
                ST_DEAD: begin
                    if (new_ctrl == 2'b00) begin
                        state_d = ST_RUN;
                        cur_d   = 2'b00;
                        cnt_d   = '0;
                    end else if (new_ctrl != pend_q) begin
                        pend_d = new_ctrl;
                        cnt_d  = DEAD_LOAD;
                    end else if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                        cur_d   = pend_q;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
            // Outputs are registered from the next state so a change is visible right after its edge.
            dead_d = (state_d == ST_DEAD);
            ctrl_d = dead_d ? 2'b00 : cur_d;
            pwm_d  = !dead_d && (cur_d != 2'b00) && pwm_raw[g];
        end

        always_ff @(posedge PCLK or negedge PRESERN) begin
            if (!PRESERN) begin
                state_q <= ST_RUN;
                cur_q   <= 2'b00;
                pend_q  <= 2'b00;
                cnt_q   <= '0;
                ctrl_q  <= 2'b00;
                pwm_q   <= 1'b0;
                dead_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cur_q   <= cur_d;
                pend_q  <= pend_d;
                cnt_q   <= cnt_d;
                ctrl_q  <= ctrl_d;
                pwm_q   <= pwm_d;
                dead_q  <= dead_d;
            end
        end

        assign ctrl_out[g] = ctrl_q;
        assign pwm_out[g]  = pwm_q;
        assign dead_out[g] = dead_q;
    end

    // A new illegal code wins over a simultaneous clear.
    assign fault_d = illegal | (fault_q & ~{2{fault_clr}});

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            fault_q <= '0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign motor1_ctrl = ctrl_out[0];
    assign motor1_pwm  = pwm_out[0];
    assign motor2_ctrl = ctrl_out[1];
    assign motor2_pwm  = pwm_out[1];
    assign dead_active = dead_out;
    assign fault       = fault_q;

endmodule
